// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter.
//   arb_state_t     - arbiter FSM states (IDLE, BUSY)
//   DEFAULT_TIMEOUT - default stall limit in clk cycles
//   rr_next         - next index in a modulo-n rotation
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    // Successor of idx in the ring 0..n-1.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first requester strictly after last_owner, in ring order, whose request
// bit is set; last_owner itself is examined last.
//   req        in   NREQ   request vector
//   last_owner in   IDXW   index that was served most recently
//   idx        out  IDXW   selected index (0 when none)
//   any        out  1      at least one request is set
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_owner,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    always_comb begin
        int unsigned cand;
        idx  = '0;
        any  = 1'b0;
        cand = 32'(last_owner);
        // Walk the whole ring once; the first hit wins.
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = rr_next(cand, NREQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: message-level round-robin arbiter feeding one UART TX byte stream.
// A requester is granted for a whole message (until a byte with req_last transfers).
// Arbitration takes one IDLE cycle; while BUSY the owner's handshake is passed straight
// through to the TX path.
//
// Optional feature (macro UART_TX_ARB_TIMEOUT_EN): a stall counter that releases the
// grant with a one-cycle abort pulse after TIMEOUT consecutive cycles in which the owner
// has no byte to offer. Without the macro the grant is held indefinitely and abort is 0.
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req_valid  in   NREQ      per-requester byte valid
//   req_data   in   NREQ*8    per-requester byte, requester i at [8*i +: 8]
//   req_last   in   NREQ      final byte of a message
//   req_ready  out  NREQ      per-requester byte accepted
//   tx_valid   out  1         byte valid toward TX path
//   tx_data    out  8         byte toward TX path
//   tx_ready   in   1         TX path accepts the byte
//   grant_id   out  log2 NREQ current owner index
//   busy       out  1         a message is in progress
//   abort      out  1         one-cycle pulse on timeout release
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    abort
);

    localparam int unsigned IDXW = $clog2(NREQ);

    arb_state_t      state_q;
    logic [IDXW-1:0] grant_q;
    logic [IDXW-1:0] last_owner_q;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            own_valid;
    logic            own_last;
    logic            xfer;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    assign own_valid = req_valid[grant_q];
    assign own_last  = req_last[grant_q];
    assign xfer      = (state_q == BUSY) && own_valid && tx_ready;

    // Owner handshake passes through combinationally; everything is quiet in IDLE.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (state_q == BUSY) begin
            tx_valid           = own_valid;
            tx_data            = req_data[32'(grant_q)*8 +: 8];
            req_ready[grant_q] = tx_ready;
        end
    end

    assign busy     = (state_q == BUSY);
    assign grant_id = grant_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] stall_q;
    logic            abort_q;

    assign abort = abort_q;
`else
    // TIMEOUT only matters when the stall counter is built.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign abort          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            // Ring starts just before requester 0 so it has first priority.
            last_owner_q <= IDXW'(NREQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_q      <= '0;
            abort_q      <= 1'b0;
`endif
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            abort_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        stall_q <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (xfer && own_last) begin
                        last_owner_q <= grant_q;
                        state_q      <= IDLE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // Only an absent owner byte counts as a stall; TX backpressure holds.
                    if (xfer) begin
                        stall_q <= '0;
                    end else if (!own_valid) begin
                        if (stall_q == CNTW'(TIMEOUT - 1)) begin
                            abort_q      <= 1'b1;
                            last_owner_q <= grant_q;
                            state_q      <= IDLE;
                            stall_q      <= '0;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, stall limit in clk cycles for a granted requester.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  NREQx8  per-requester byte.
REQ-007 SHALL have port req_last  input  NREQ  marks the final byte of a message.
REQ-008 SHALL have port req_ready  output  NREQ  per-requester byte accepted.
REQ-009 SHALL have port tx_valid  output  1  byte valid toward the uart TX path.
REQ-010 SHALL have port tx_data  output  8  byte toward the uart TX path.
REQ-011 SHALL have port tx_ready  input  1  uart TX path accepts the byte.
REQ-012 SHALL have port grant_id  output  $clog2(NREQ)  current owner index.
REQ-013 SHALL have port busy  output  1  a message is in progress.
REQ-014 SHALL have port abort  output  1  one-cycle pulse on timeout release.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 In IDLE with any req_valid high, SHALL select the first requester after last_owner in round-robin order, register grant_id, and enter BUSY next cycle.
REQ-017 In IDLE, SHALL hold tx_valid=0 and req_ready=0; arbitration costs exactly one cycle.
REQ-018 In BUSY, SHALL drive tx_valid=req_valid[grant_id], tx_data=req_data[grant_id], and req_ready[grant_id]=tx_ready, all combinationally; other req_ready bits SHALL be 0.
REQ-019 A beat SHALL transfer when tx_valid and tx_ready are both high; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-020 On transfer with req_last[grant_id]=1, SHALL update last_owner to grant_id and return to IDLE; no back-to-back grant in the same cycle.
REQ-021 Grant SHALL NOT change mid-message; other requesters wait regardless of their valid.
REQ-022 Simultaneous requests SHALL be served in rotating order; a continuously requesting port SHALL wait at most NREQ-1 messages.
REQ-023 Single requester repeatedly requesting SHALL be re-granted every message (IDLE gap of one cycle).
REQ-024 busy SHALL equal (state==BUSY).

Reset
REQ-025 On rst_n low, SHALL asynchronously force state=IDLE, grant_id=0, last_owner=NREQ-1, busy=0, abort=0, stall counter=0.
REQ-026 Reset asserted mid-message SHALL drop the message; after release, requester 0 has first priority.

Configuration
REQ-027 With UART_TX_ARB_TIMEOUT_EN defined, SHALL count consecutive BUSY cycles with req_valid[grant_id]=0, clear the counter on any transfer, and on reaching TIMEOUT pulse abort for one cycle, set last_owner=grant_id, and return to IDLE.
REQ-028 Stalls caused by tx_ready=0 with tx_valid=1 SHALL NOT advance the counter.
REQ-029 Without UART_TX_ARB_TIMEOUT_EN, SHALL contain no counter, tie abort to 0, and hold grant indefinitely.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the default TIMEOUT constant.
REQ-031 Round-robin selection SHALL be one sub-module rr_pick (inputs request vector, last_owner; output index, any).

Verification
REQ-032 Reset: rst_n=0 mid-message -> tx_valid=0, busy=0, grant_id=0 in same cycle; after release req0 and req3 valid -> req0 granted.
REQ-033 Contention: req0..req3 each send 2-byte messages, all valid at t0 -> tx_data order req0,req0,req1,req1,req2,req2,req3,req3, one IDLE cycle between messages.
REQ-034 Lock: req1 mid 3-byte message, req2 asserts valid -> req2 ready stays 0 until req1 last byte transfers.
REQ-035 Backpressure: tx_ready=0 for 10 cycles with byte 0xA5 valid -> tx_data holds 0xA5, no abort, transfers on tx_ready=1.
REQ-036 Timeout (macro on, TIMEOUT=16): granted req2 drops valid after 1 byte -> abort pulses exactly 16 stall cycles later, busy=0 next cycle, req3 granted next.
REQ-037 Macro off, same stimulus -> abort never asserts, grant stays at req2.
